pc_update_unit: RTL and testbench

- Parametrised program-counter register and next-PC generator for the single-cycle CPU datapath.
- Computes the sequential address and the branch/jump target.
- Freezes the PC while the memory hierarchy asserts BUSYWAIT.
- Latches the next-PC decision made on the first stall cycle, so control-signal changes during a cache miss cannot corrupt the redirect.
- Sits between the control unit / ALU ZERO flag and the instruction-cache address port; also counts retired instructions.

---
 rtl/pc_pkg.sv | 26 ++
 rtl/pc_update_unit_if.sv | 31 +++
 rtl/pc_target_calc.sv | 28 ++
 rtl/pc_update_unit.sv | 90 +++++++++
 tb/tb_pc_update_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types, default widths and the offset helper for the program-counter
// datapath. The decode stage reuses the same offset helper.
package pc_pkg;

  localparam int DEFAULT_PC_WIDTH  = 32;
  localparam int DEFAULT_IMM_WIDTH = 8;
  localparam int EXT_WIDTH         = 64;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_STALL = 1'b1
  } pc_state_e;

  // Sign-extends the low imm_width bits of imm, then shifts left by shift.
  // Callers truncate the result to their own address width.
  function automatic logic [EXT_WIDTH-1:0] sext_shift(
    input logic [EXT_WIDTH-1:0] imm,
    input int unsigned          imm_width,
    input int unsigned          shift
  );
    logic [EXT_WIDTH-1:0] aligned;
    aligned = imm << (EXT_WIDTH - imm_width);
    return EXT_WIDTH'($signed(aligned) >>> (EXT_WIDTH - imm_width)) << shift;
  endfunction

endpackage

// File: rtl/pc_update_unit_if.sv
// Control/status bundle between the control unit, the memory stall logic
// and the PC update unit.
interface pc_update_unit_if
  import pc_pkg::*;
#(
  parameter int PC_WIDTH  = DEFAULT_PC_WIDTH,
  parameter int IMM_WIDTH = DEFAULT_IMM_WIDTH,
  parameter int CNT_WIDTH = 32
) ();

  logic                 BUSYWAIT;
  logic                 BEQ_signal;
  logic                 ZERO;
  logic                 J_signal;
  logic [IMM_WIDTH-1:0] IMMEDIATE;
  logic [PC_WIDTH-1:0]  PC;
  logic [PC_WIDTH-1:0]  PC_SEQ;
  logic                 STALLED;
  logic [CNT_WIDTH-1:0] RETIRED;

  modport master (
    output BUSYWAIT, BEQ_signal, ZERO, J_signal, IMMEDIATE,
    input  PC, PC_SEQ, STALLED, RETIRED
  );

  modport slave (
    input  BUSYWAIT, BEQ_signal, ZERO, J_signal, IMMEDIATE,
    output PC, PC_SEQ, STALLED, RETIRED
  );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC arithmetic: sequential address and branch/jump target,
// all modulo 2^PC_WIDTH.
module pc_target_calc
  import pc_pkg::*;
#(
  parameter int PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int IMM_WIDTH    = DEFAULT_IMM_WIDTH,
  parameter int INSTR_BYTES  = 4,
  parameter int BRANCH_SHIFT = 2
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic                 take,
  output logic [PC_WIDTH-1:0]  seq,
  output logic [PC_WIDTH-1:0]  nxt
);

  logic [PC_WIDTH-1:0] off;
  logic [PC_WIDTH-1:0] tgt;

  always_comb begin
    seq = pc + PC_WIDTH'(INSTR_BYTES);
    off = PC_WIDTH'(sext_shift(EXT_WIDTH'(imm), IMM_WIDTH, BRANCH_SHIFT));
    tgt = seq + off;
    nxt = take ? tgt : seq;
  end

endmodule

// File: rtl/pc_update_unit.sv
// Program-counter register with stall handling: the next-PC decision taken on
// the first stall cycle is latched and applied when the stall clears.
module pc_update_unit
  import pc_pkg::*;
#(
  parameter int                  PC_WIDTH     = DEFAULT_PC_WIDTH,
  parameter int                  IMM_WIDTH    = DEFAULT_IMM_WIDTH,
  parameter int                  INSTR_BYTES  = 4,
  parameter int                  BRANCH_SHIFT = 2,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                  CNT_WIDTH    = 32
) (
  input logic              CLK,
  input logic              RESET,
  pc_update_unit_if.slave  bus
);

  pc_state_e            state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  pend_q, pend_d;
  logic [CNT_WIDTH-1:0] ret_q, ret_d;
  logic [PC_WIDTH-1:0]  seq;
  logic [PC_WIDTH-1:0]  nxt;
  logic                 take;

  // A jump and a taken branch share the same target formula.
  assign take = bus.J_signal | (bus.BEQ_signal & bus.ZERO);

  pc_target_calc #(
    .PC_WIDTH    (PC_WIDTH),
    .IMM_WIDTH   (IMM_WIDTH),
    .INSTR_BYTES (INSTR_BYTES),
    .BRANCH_SHIFT(BRANCH_SHIFT)
  ) u_target (
    .pc  (pc_q),
    .imm (bus.IMMEDIATE),
    .take(take),
    .seq (seq),
    .nxt (nxt)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    ret_d   = ret_q;
    unique case (state_q)
      PC_RUN: begin
        if (bus.BUSYWAIT) begin
          pend_d  = nxt;
          state_d = PC_STALL;
        end else begin
          pc_d  = nxt;
          ret_d = ret_q + CNT_WIDTH'(1);
        end
      end
      PC_STALL: begin
        // Control inputs are ignored here; only the latched target matters.
        if (!bus.BUSYWAIT) begin
          pc_d    = pend_q;
          ret_d   = ret_q + CNT_WIDTH'(1);
          state_d = PC_RUN;
        end
      end
      default: state_d = PC_RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (!RESET) begin
      state_q <= PC_RUN;
      pc_q    <= RESET_VECTOR;
      pend_q  <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.PC      = pc_q;
  assign bus.PC_SEQ  = seq;
  assign bus.STALLED = (state_q == PC_STALL);
  assign bus.RETIRED = ret_q;

endmodule

// File: tb/tb_pc_update_unit.sv
// Scoreboarded bench for pc_update_unit: default-parameter instance for the
// main scenarios, plus a narrow instance for the parameter sweep.
module tb_pc_update_unit;

  typedef struct {
    logic [31:0] pc;
    logic        st;
    logic [31:0] ret;
  } exp_t;

  typedef struct {
    logic        busy;
    logic        beq;
    logic        zero;
    logic        j;
    logic [7:0]  imm;
    logic [31:0] pc;
    logic        st;
    logic [31:0] ret;
  } row_t;

  logic clk;
  logic rst_a;
  logic rst_b;
  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  pc_update_unit_if bus_a ();
  pc_update_unit_if #(.PC_WIDTH(16), .IMM_WIDTH(12), .CNT_WIDTH(4)) bus_b ();

  pc_update_unit dut_a (
    .CLK  (clk),
    .RESET(rst_a),
    .bus  (bus_a.slave)
  );

  pc_update_unit #(
    .PC_WIDTH    (16),
    .IMM_WIDTH   (12),
    .INSTR_BYTES (2),
    .BRANCH_SHIFT(1),
    .RESET_VECTOR(16'h0100),
    .CNT_WIDTH   (4)
  ) dut_b (
    .CLK  (clk),
    .RESET(rst_b),
    .bus  (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  function automatic row_t row(input logic busy, input logic beq, input logic zero,
                               input logic j, input logic [7:0] imm,
                               input logic [31:0] pc, input logic st, input logic [31:0] ret);
    row_t r;
    r.busy = busy; r.beq = beq; r.zero = zero; r.j = j; r.imm = imm;
    r.pc = pc; r.st = st; r.ret = ret;
    return r;
  endfunction

  // Drives one cycle of stimulus on instance A and records what it must produce.
  task automatic drive_a(input row_t r);
    exp_t e;
    bus_a.BUSYWAIT   = r.busy;
    bus_a.BEQ_signal = r.beq;
    bus_a.ZERO       = r.zero;
    bus_a.J_signal   = r.j;
    bus_a.IMMEDIATE  = r.imm;
    e.pc = r.pc; e.st = r.st; e.ret = r.ret;
    sb.push_back(e);
  endtask

  task automatic pulse_reset_a();
    rst_a = 1'b0;
    #1;
    rst_a = 1'b1;
  endtask

  task automatic test_reset();
    row_t rows[4];
    exp_t e;
    rows[0] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0, 32'd1);
    rows[1] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  1'b0, 32'd2);
    rows[2] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd12, 1'b0, 32'd3);
    rows[3] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd16, 1'b0, 32'd4);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {32'd0, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got pc=%h stalled=%b retired=%0d, expected pc=0 stalled=0 retired=0",
               bus_a.PC, bus_a.STALLED, bus_a.RETIRED);
    end
    n_checks++;
    if (bus_a.PC_SEQ !== 32'd4) begin
      n_fail++;
      $display("FAIL reset_pc_seq: got %h, expected 00000004", bus_a.PC_SEQ);
    end
    rst_a = 1'b1;
    foreach (rows[i]) begin
      drive_a(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL seq_run[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_a.PC, bus_a.STALLED, bus_a.RETIRED, e.pc, e.st, e.ret);
      end
    end
    rst_a = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.PC, bus_a.RETIRED} !== {32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got pc=%h retired=%0d, expected pc=0 retired=0",
               bus_a.PC, bus_a.RETIRED);
    end
    rst_a = 1'b1;
  endtask

  task automatic test_branch();
    row_t rows[7];
    exp_t e;
    rows[0] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0, 32'd1);
    rows[1] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  1'b0, 32'd2);
    rows[2] = row(1'b0, 1'b1, 1'b1, 1'b0, 8'h03, 32'd24, 1'b0, 32'd3);
    rows[3] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0, 32'd1);
    rows[4] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  1'b0, 32'd2);
    rows[5] = row(1'b0, 1'b1, 1'b0, 1'b0, 8'h03, 32'd12, 1'b0, 32'd3);
    rows[6] = row(1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 32'd20, 1'b0, 32'd4);
    foreach (rows[i]) begin
      if (i == 3) pulse_reset_a();
      drive_a(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL branch[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_a.PC, bus_a.STALLED, bus_a.RETIRED, e.pc, e.st, e.ret);
      end
    end
  endtask

  task automatic test_jump_wrap();
    row_t rows[7];
    exp_t e;
    rows[0] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,         1'b0, 32'd1);
    rows[1] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,         1'b0, 32'd2);
    rows[2] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd12,        1'b0, 32'd3);
    rows[3] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd16,        1'b0, 32'd4);
    rows[4] = row(1'b0, 1'b0, 1'b0, 1'b1, 8'hFB, 32'd0,         1'b0, 32'd5);
    rows[5] = row(1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 32'hFFFF_FFFC, 1'b0, 32'd6);
    rows[6] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,         1'b0, 32'd7);
    pulse_reset_a();
    foreach (rows[i]) begin
      drive_a(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL jump_wrap[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_a.PC, bus_a.STALLED, bus_a.RETIRED, e.pc, e.st, e.ret);
      end
    end
  endtask

  task automatic test_stall_latch();
    row_t rows[5];
    exp_t e;
    rows[0] = row(1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 32'd40, 1'b0, 32'd1);
    rows[1] = row(1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 32'd40, 1'b1, 32'd1);
    rows[2] = row(1'b1, 1'b0, 1'b1, 1'b0, 8'h02, 32'd40, 1'b1, 32'd1);
    rows[3] = row(1'b1, 1'b0, 1'b0, 1'b0, 8'h7F, 32'd40, 1'b1, 32'd1);
    rows[4] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd52, 1'b0, 32'd2);
    pulse_reset_a();
    foreach (rows[i]) begin
      drive_a(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL stall_latch[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_a.PC, bus_a.STALLED, bus_a.RETIRED, e.pc, e.st, e.ret);
      end
    end
  endtask

  task automatic test_pulse_and_reset();
    row_t rows[7];
    exp_t e;
    rows[0] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0, 32'd1);
    rows[1] = row(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b1, 32'd1);
    rows[2] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd8,  1'b0, 32'd2);
    rows[3] = row(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 32'd8,  1'b1, 32'd2);
    rows[4] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd20, 1'b0, 32'd3);
    rows[5] = row(1'b1, 1'b0, 1'b0, 1'b1, 8'h0A, 32'd20, 1'b1, 32'd3);
    rows[6] = row(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd4,  1'b0, 32'd1);
    pulse_reset_a();
    foreach (rows[i]) begin
      if (i == 6) begin
        rst_a = 1'b0;
        #1;
        n_checks++;
        if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {32'd0, 1'b0, 32'd0}) begin
          n_fail++;
          $display("FAIL reset_mid_stall: got pc=%h stalled=%b retired=%0d, expected pc=0 stalled=0 retired=0",
                   bus_a.PC, bus_a.STALLED, bus_a.RETIRED);
        end
        rst_a = 1'b1;
      end
      drive_a(rows[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({bus_a.PC, bus_a.STALLED, bus_a.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL pulse_reset[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_a.PC, bus_a.STALLED, bus_a.RETIRED, e.pc, e.st, e.ret);
      end
    end
  endtask

  task automatic test_param_sweep();
    exp_t e;
    n_checks++;
    if ({bus_b.PC, bus_b.PC_SEQ, bus_b.RETIRED} !== {16'h0100, 16'h0102, 4'd0}) begin
      n_fail++;
      $display("FAIL param_reset: got pc=%h pc_seq=%h retired=%0d, expected pc=0100 pc_seq=0102 retired=0",
               bus_b.PC, bus_b.PC_SEQ, bus_b.RETIRED);
    end
    rst_b = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus_b.BUSYWAIT   = 1'b0;
      bus_b.BEQ_signal = 1'b0;
      bus_b.ZERO       = 1'b0;
      bus_b.J_signal   = (i < 2);
      bus_b.IMMEDIATE  = (i == 0) ? 12'hFFF : (i == 1) ? 12'hF7E : 12'h000;
      e.pc  = (i == 0) ? 32'h0100 : (i == 1) ? 32'hFFFE : 32'(2 * (i - 2));
      e.st  = 1'b0;
      e.ret = 32'((i + 1) % 16);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      n_checks++;
      if ({16'h0000, bus_b.PC, bus_b.STALLED, 28'h0, bus_b.RETIRED} !== {e.pc, e.st, e.ret}) begin
        n_fail++;
        $display("FAIL param_sweep[%0d]: got pc=%h stalled=%b retired=%0d, expected pc=%h stalled=%b retired=%0d",
                 i, bus_b.PC, bus_b.STALLED, bus_b.RETIRED, e.pc, e.st, e.ret);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_a = 1'b0;
    rst_b = 1'b0;
    bus_a.BUSYWAIT = 1'b0; bus_a.BEQ_signal = 1'b0; bus_a.ZERO = 1'b0;
    bus_a.J_signal = 1'b0; bus_a.IMMEDIATE  = '0;
    bus_b.BUSYWAIT = 1'b0; bus_b.BEQ_signal = 1'b0; bus_b.ZERO = 1'b0;
    bus_b.J_signal = 1'b0; bus_b.IMMEDIATE  = '0;

    test_reset();
    test_branch();
    test_jump_wrap();
    test_stall_latch();
    test_pulse_and_reset();
    test_param_sweep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
